x25519_to_affine: RTL and testbench



---
 rtl/x25519_pkg.sv | 20 ++
 rtl/fe25519_mul.sv | 65 ++++++
 rtl/x25519_to_affine.sv | 121 ++++++++++++
 tb/tb_x25519_to_affine.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/x25519_pkg.sv
// Shared constants and types for the X25519 projective-to-affine converter:
// field prime, inversion exponent, FSM state encoding and fixed latencies.
package x25519_pkg;

    localparam logic [255:0] P25519 =
        256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
    localparam logic [255:0] E_INV =
        256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffeb;

    localparam int MUL_LATENCY  = 257;
    localparam int CONV_LATENCY = 131322;

    typedef enum logic [1:0] {
        IDLE,
        SQR,
        MUL,
        FIN
    } state_t;

endpackage

// File: rtl/fe25519_mul.sv
// Bit-serial modular multiplier mod 2^255-19: MSB-first interleaved shift-add,
// one load cycle plus 256 iterations, result fully reduced.
module fe25519_mul
    import x25519_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] a,
    input  logic [255:0] b,
    output logic         done,
    output logic [255:0] r
);

    logic         running;
    logic [7:0]   cnt;
    logic [255:0] a_q;
    logic [255:0] b_q;

    // r < p and a < p keep 2r + a below 3p, so two subtracts always suffice.
    function automatic logic [255:0] mac_step(input logic [255:0] acc,
                                              input logic [255:0] addend,
                                              input logic         bit_set);
        logic [257:0] t;
        t = {2'b00, acc} << 1;
        if (bit_set) t = t + {2'b00, addend};
        if (t >= {2'b00, P25519}) t = t - {2'b00, P25519};
        if (t >= {2'b00, P25519}) t = t - {2'b00, P25519};
        return t[255:0];
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= 8'd0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!running) begin
                if (start) begin
                    running <= 1'b1;
                    cnt     <= 8'd0;
                end
            end else begin
                cnt <= cnt + 8'd1;
                if (cnt == 8'd255) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!running && start) begin
            a_q <= a;
            b_q <= b;
            r   <= 256'd0;
        end else if (running) begin
            r   <= mac_step(r, a_q, b_q[255]);
            b_q <= b_q << 1;
        end
    end

endmodule

// File: rtl/x25519_to_affine.sv
// Affine u = X * Z^(p-2) mod p via a fixed square-and-multiply schedule over one
// shared multiplier. Optional zero_point output under X25519_AFFINE_ZERO_FLAG_EN.
module x25519_to_affine
    import x25519_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] x_in,
    input  logic [255:0] z_in,
    output logic         busy,
    output logic         done,
    output logic [255:0] x_out
`ifdef X25519_AFFINE_ZERO_FLAG_EN
    ,
    output logic         zero_point
`endif
);

    state_t       state, state_nxt;
    logic [7:0]   idx;
    logic         issued;
    logic [255:0] acc, x_q, z_q;
    logic         mul_start, mul_done;
    logic [255:0] mul_b, mul_r;
    logic         capture;

    function automatic logic [255:0] reduce(input logic [255:0] v);
        logic [255:0] m;
        m = {1'b0, v[254:0]};
        if (m >= P25519) m = m - P25519;
        return m;
    endfunction

    assign busy    = (state != IDLE);
    assign capture = (state == IDLE) && start;

    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        mul_b     = acc;
        case (state)
            IDLE: if (start) state_nxt = SQR;
            SQR: begin
                mul_start = !issued;
                if (mul_done) begin
                    if (E_INV[idx])      state_nxt = MUL;
                    else if (idx == 8'd0) state_nxt = FIN;
                    else                  state_nxt = SQR;
                end
            end
            MUL: begin
                mul_b     = z_q;
                mul_start = !issued;
                if (mul_done) state_nxt = (idx == 8'd0) ? FIN : SQR;
            end
            FIN: begin
                mul_b     = x_q;
                mul_start = !issued;
                if (mul_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    fe25519_mul u_mul (
        .clock (clock),
        .reset (reset),
        .start (mul_start),
        .a     (acc),
        .b     (mul_b),
        .done  (mul_done),
        .r     (mul_r)
    );

`ifdef X25519_AFFINE_ZERO_FLAG_EN
    logic z_zero;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= 8'd0;
            issued <= 1'b0;
            done   <= 1'b0;
            x_out  <= 256'd0;
`ifdef X25519_AFFINE_ZERO_FLAG_EN
            zero_point <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            done  <= (state == FIN) && mul_done;
            if (mul_start)     issued <= 1'b1;
            else if (mul_done) issued <= 1'b0;
            if (capture) idx <= 8'd254;
            else if (mul_done && ((state == MUL) || (state == SQR && !E_INV[idx])))
                idx <= idx - 8'd1;
            if ((state == FIN) && mul_done) begin
                x_out <= mul_r;
`ifdef X25519_AFFINE_ZERO_FLAG_EN
                zero_point <= z_zero;
`endif
            end
        end
    end

    // Operands and accumulator carry no reset; capture always reloads them.
    always_ff @(posedge clock) begin
        if (capture) begin
            x_q <= reduce(x_in);
            z_q <= reduce(z_in);
            acc <= 256'd1;
`ifdef X25519_AFFINE_ZERO_FLAG_EN
            z_zero <= (reduce(z_in) == 256'd0);
`endif
        end else if (mul_done && (state == SQR || state == MUL)) begin
            acc <= mul_r;
        end
    end

endmodule

// File: tb/tb_x25519_to_affine.sv
// Bench for x25519_to_affine: fixed vectors plus a random vector against a
// wide-arithmetic modular reference; covers latency, busy start, zero Z and reset.
module tb_x25519_to_affine;

    localparam logic [255:0] P_REF =
        256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
    localparam int LAT = 131322;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [255:0] x_in, z_in;
    logic         busy, done;
    logic [255:0] x_out;
`ifdef X25519_AFFINE_ZERO_FLAG_EN
    logic         zero_point;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    x25519_to_affine dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .x_in  (x_in),
        .z_in  (z_in),
        .busy  (busy),
        .done  (done),
        .x_out (x_out)
`ifdef X25519_AFFINE_ZERO_FLAG_EN
        ,
        .zero_point (zero_point)
`endif
    );

    typedef struct {
        logic [255:0] x;
        logic [255:0] z;
        logic [255:0] exp;
        logic         zf;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] mmul(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] t;
        t = ({256'd0, a} * {256'd0, b}) % {256'd0, P_REF};
        return t[255:0];
    endfunction

    function automatic logic [255:0] mpow(input logic [255:0] base, input logic [255:0] e);
        logic [255:0] r;
        r = 256'd1;
        for (int k = 255; k >= 0; k--) begin
            r = mmul(r, r);
            if (e[k]) r = mmul(r, base);
        end
        return r;
    endfunction

    function automatic logic [255:0] ref_affine(input logic [255:0] x, input logic [255:0] z);
        logic [255:0] xr, zr;
        xr = {1'b0, x[254:0]} % P_REF;
        zr = {1'b0, z[254:0]} % P_REF;
        return mmul(xr, mpow(zr, P_REF - 256'd2));
    endfunction

    task automatic run_job(input vec_t v, input bit poke, input string tag);
        int  n;
        bit  got;
        @(negedge clock);
        x_in  = v.x;
        z_in  = v.z;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        x_in  = rand256();
        z_in  = rand256();
        check({tag, "_busy_rise"}, {255'd0, busy}, 256'd1);
        n   = 0;
        got = 0;
        while (n < LAT + 2000 && !got) begin
            @(posedge clock);
            #1;
            n++;
            if (poke && n == 1000) begin
                start = 1'b1;
                x_in  = rand256();
                z_in  = 256'd3;
            end
            if (poke && n == 1001) start = 1'b0;
            if (done) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout no done within %0d cycles", tag, n);
        end else begin
            check({tag, "_latency"}, 256'(n), 256'(LAT));
            check({tag, "_x_out"}, x_out, v.exp);
            check({tag, "_busy_at_done"}, {255'd0, busy}, 256'd0);
`ifdef X25519_AFFINE_ZERO_FLAG_EN
            check({tag, "_zero_point"}, {255'd0, zero_point}, {255'd0, v.zf});
`endif
            @(posedge clock);
            #1;
            check({tag, "_done_pulse"}, {255'd0, done}, 256'd0);
            check({tag, "_x_out_hold"}, x_out, v.exp);
        end
    endtask

    initial begin
        logic [255:0] rx, rz;
        reset = 1'b1;
        start = 1'b0;
        x_in  = 256'd0;
        z_in  = 256'd0;

        vecs[0] = '{256'd1, 256'd2, (256'd1 << 254) - 256'd9, 1'b0};
        vecs[1] = '{(256'd1 << 255) | 256'd5, P_REF + 256'd1, 256'd5, 1'b0};
        vecs[2] = '{256'd123, 256'd0, 256'd0, 1'b1};
        vecs[3] = '{256'd9, 256'd1, 256'd9, 1'b0};
        rx = rand256();
        rz = rand256();
        vecs[4] = '{rx, rz, ref_affine(rx, rz), (({1'b0, rz[254:0]} % P_REF) == 256'd0)};

        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", {255'd0, busy}, 256'd0);
        check("reset_done", {255'd0, done}, 256'd0);
        check("reset_x_out", x_out, 256'd0);
`ifdef X25519_AFFINE_ZERO_FLAG_EN
        check("reset_zero_point", {255'd0, zero_point}, 256'd0);
`endif
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_job(vecs[i], i == 0, $sformatf("vec%0d", i));

        // Abort a job part-way through with an asynchronous reset.
        @(negedge clock);
        x_in  = 256'd9;
        z_in  = 256'd1;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (59999) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", {255'd0, busy}, 256'd0);
        check("abort_done", {255'd0, done}, 256'd0);
        check("abort_x_out", x_out, 256'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("abort_idle_busy", {255'd0, busy}, 256'd0);
        check("abort_idle_done", {255'd0, done}, 256'd0);

        run_job(vecs[3], 1'b0, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
